// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and helpers for the reset sequencer (rst_seq_ctrl).
//   rst_seq_state_e : sequencer phases HOLD -> WAIT -> RUN
//   delay_t         : default-width per-domain release delay
//   hold_cnt_w()    : width of the inline hold counter for a given hold length
//   HOLD_CNT_W      : hold counter width for the default hold length
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  localparam int DELAY_W_DEF = 8;
  localparam int HOLD_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } rst_seq_state_e;

  typedef logic [DELAY_W_DEF-1:0] delay_t;

  // The hold counter only has to reach HoldCycles-1, so log2 of the hold
  // length is enough; never narrower than one bit.
  function automatic int hold_cnt_w(input int hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

  localparam int HOLD_CNT_W = hold_cnt_w(HOLD_CYCLES_DEF);

endpackage

// File: rtl/rst_seq_cnt.sv
// -----------------------------------------------------------------------------
// rst_seq_cnt
// Loadable down-counter used for the inter-domain release delay.
// Ports:
//   clk_i       in   clock
//   load_i      in   load load_val_i on the next edge (has priority)
//   load_val_i  in   value to load
//   dec_i       in   decrement on the next edge (ignored while loading)
//   value_o     out  current count
//   zero_o      out  count is zero
// The count is pure data: it is always loaded before it is consulted, so it
// carries no reset.
// -----------------------------------------------------------------------------
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int Width = DELAY_W_DEF
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] value_o,
  output logic             zero_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign value_o = r_cnt;
  assign zero_o  = (r_cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
// Reset sequencer feeding the per-domain reset generators. All domain resets
// are held for HoldCycles, then released one at a time in index order, each
// after its own programmable delay. A software request while fully released
// re-runs the sequence from the lowest requested domain upward.
//
// Optional build macro: RST_SEQ_TEST_BYPASS_EN
//   Adds test_mode_i; when high, dom_rst_no follows ~rst_i combinationally on
//   every domain and seq_done_o reads 1. The FSM keeps running underneath.
//
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   test_mode_i   in   bypass select (only with RST_SEQ_TEST_BYPASS_EN)
//   cfg_we_i      in   delay register write strobe
//   cfg_idx_i     in   delay register index (out of range -> write dropped)
//   cfg_delay_i   in   delay value to write
//   sw_rst_req_i  in   per-domain software reset request (level)
//   dom_rst_no    out  active-low domain resets, registered
//   seq_busy_o    out  sequence in progress (HOLD or WAIT)
//   seq_done_o    out  all domains released (RUN)
// -----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NumDomains   = 4,
  parameter int DelayWidth   = DELAY_W_DEF,
  parameter int HoldCycles   = HOLD_CYCLES_DEF,
  parameter int DefaultDelay = 2,
  localparam int IdxW        = $clog2(NumDomains)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef RST_SEQ_TEST_BYPASS_EN
  input  logic                  test_mode_i,
`endif
  input  logic                  cfg_we_i,
  input  logic [IdxW-1:0]       cfg_idx_i,
  input  logic [DelayWidth-1:0] cfg_delay_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  output logic [NumDomains-1:0] dom_rst_no,
  output logic                  seq_busy_o,
  output logic                  seq_done_o
);

  localparam int                HoldW    = hold_cnt_w(HoldCycles);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HoldCycles - 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NumDomains - 1);

  // Lowest requested domain index.
  function automatic logic [IdxW-1:0] lowest_set(input logic [NumDomains-1:0] v);
    lowest_set = '0;
    for (int i = NumDomains - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IdxW'(i);
    end
  endfunction

  // Bits strictly below k stay released when a request restarts from k.
  function automatic logic [NumDomains-1:0] keep_mask(input logic [IdxW-1:0] k);
    keep_mask = '0;
    for (int i = 0; i < NumDomains; i++) begin
      if (i < int'(k)) keep_mask[i] = 1'b1;
    end
  endfunction

  rst_seq_state_e        r_state;
  logic                  r_settle;
  logic [IdxW-1:0]       r_start;
  logic [IdxW-1:0]       r_idx;
  logic [HoldW-1:0]      r_hold_cnt;
  logic [NumDomains-1:0] r_dom_rst_n;
  logic                  r_busy;
  logic                  r_done;
  logic [DelayWidth-1:0] r_delay [NumDomains];

  logic                  w_hold_exit;
  logic                  w_last;
  logic [IdxW-1:0]       w_next_idx;
  logic [IdxW-1:0]       w_req_low;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;
  logic [DelayWidth-1:0] w_cnt_val;
  logic [DelayWidth-1:0] w_load_val;

  // r_settle burns the first edge after rst_i drops so that the first
  // domain releases HoldCycles+1+delay edges after reset deassertion; a
  // software-requested restart enters HOLD already settled.
  assign w_hold_exit = (r_state == HOLD) && !r_settle && (r_hold_cnt == HoldLast);
  assign w_last      = (r_idx == LastIdx);
  assign w_next_idx  = r_idx + 1'b1;
  assign w_req_low   = lowest_set(sw_rst_req_i);

  // The delay is sampled only at load time, so rewriting the register that
  // is currently counting does not disturb the running wait.
  assign w_cnt_load  = w_hold_exit || ((r_state == WAIT) && w_cnt_zero && !w_last);
  assign w_load_val  = w_hold_exit ? r_delay[r_start] : r_delay[w_next_idx];
  assign w_cnt_dec   = (r_state == WAIT) && (w_cnt_val != '0);

  rst_seq_cnt #(
    .Width (DelayWidth)
  ) u_delay_cnt (
    .clk_i      (clk_i),
    .load_i     (w_cnt_load),
    .load_val_i (w_load_val),
    .dec_i      (w_cnt_dec),
    .value_o    (w_cnt_val),
    .zero_o     (w_cnt_zero)
  );

  // Delay registers: writable in any state, restored by rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumDomains; i++) begin
        r_delay[i] <= DelayWidth'(DefaultDelay);
      end
    end else if (cfg_we_i && (32'(cfg_idx_i) < 32'(NumDomains))) begin
      r_delay[cfg_idx_i] <= cfg_delay_i;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= HOLD;
      r_settle    <= 1'b1;
      r_start     <= '0;
      r_idx       <= '0;
      r_hold_cnt  <= '0;
      r_dom_rst_n <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_settle) begin
            r_settle <= 1'b0;
          end else if (r_hold_cnt == HoldLast) begin
            r_state <= WAIT;
            r_idx   <= r_start;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        WAIT: begin
          if (w_cnt_zero) begin
            r_dom_rst_n[r_idx] <= 1'b1;
            if (w_last) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end

        RUN: begin
          // Requests are only honoured here; HOLD/WAIT ignore them.
          if (sw_rst_req_i != '0) begin
            r_dom_rst_n <= r_dom_rst_n & keep_mask(w_req_low);
            r_start     <= w_req_low;
            r_hold_cnt  <= '0;
            r_state     <= HOLD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end

        default: begin
          r_state <= HOLD;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_busy_o = r_busy;

`ifdef RST_SEQ_TEST_BYPASS_EN
  assign dom_rst_no = test_mode_i ? {NumDomains{~rst_i}} : r_dom_rst_n;
  assign seq_done_o = test_mode_i ? 1'b1 : r_done;
`else
  assign dom_rst_no = r_dom_rst_n;
  assign seq_done_o = r_done;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Self-checking bench for rst_seq_ctrl. A schedule-based reference model
// computes the edge at which each domain must release from the delay values
// in force at load time; a negedge process compares every output each cycle.
// Directed scenarios pin the model with hand-computed edge numbers, then a
// randomized phase exercises writes, requests and resets.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int ND = 4;
  localparam int DW = 8;
  localparam int HC = 8;
  localparam int DD = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [DW-1:0] cfg_delay = '0;
  logic [ND-1:0] req = '0;
  logic          test_mode = 1'b0;
  logic [ND-1:0] dom_rst_no;
  logic          seq_busy;
  logic          seq_done;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NumDomains   (ND),
    .DelayWidth   (DW),
    .HoldCycles   (HC),
    .DefaultDelay (DD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
`ifdef RST_SEQ_TEST_BYPASS_EN
    .test_mode_i  (test_mode),
`endif
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_delay_i  (cfg_delay),
    .sw_rst_req_i (req),
    .dom_rst_no   (dom_rst_no),
    .seq_busy_o   (seq_busy),
    .seq_done_o   (seq_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (release schedule) ----------------
  int            d [ND];
  logic [ND-1:0] m_rst_n = '0;
  bit            m_run = 1'b0;
  bit            m_wait = 1'b0;
  int            m_idx = 0;
  int            m_evt = 0;
  int            edge_num = -1;
  int            m_req_edge = -1;
  int            m_rise [ND];
  int            m_done_edge = -1;

  task automatic model_step();
    int k;
    if (rst_i) begin
      edge_num    = -1;
      m_rst_n     = '0;
      m_run       = 1'b0;
      m_wait      = 1'b0;
      m_idx       = 0;
      m_evt       = HC;        // first load HC edges after the first low edge 0
      m_done_edge = -1;
      for (int i = 0; i < ND; i++) begin
        d[i]      = DD;
        m_rise[i] = -1;
      end
    end else begin
      edge_num++;
      if (m_run) begin
        if (req != '0) begin
          k = 0;
          while (!req[k]) k++;
          for (int i = k; i < ND; i++) begin
            m_rst_n[i] = 1'b0;
            m_rise[i]  = -1;
          end
          m_idx       = k;
          m_run       = 1'b0;
          m_wait      = 1'b0;
          m_evt       = edge_num + HC;
          m_req_edge  = edge_num;
          m_done_edge = -1;
        end
      end else if (!m_wait) begin
        if (edge_num == m_evt) begin
          m_wait = 1'b1;
          m_evt  = edge_num + d[m_idx] + 1;
        end
      end else if (edge_num == m_evt) begin
        m_rst_n[m_idx] = 1'b1;
        m_rise[m_idx]  = edge_num;
        if (m_idx == ND - 1) begin
          m_run       = 1'b1;
          m_wait      = 1'b0;
          m_done_edge = edge_num;
        end else begin
          m_idx++;
          m_evt = edge_num + d[m_idx] + 1;
        end
      end
      if (cfg_we && int'(cfg_idx) < ND) d[cfg_idx] = int'(cfg_delay);
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  task automatic compare_step();
    logic [ND-1:0] exp_dom;
    exp_dom = test_mode ? {ND{~rst_i}} : m_rst_n;
    check("dom_rst_no", int'(dom_rst_no), int'(exp_dom));
    check("seq_busy",   int'(seq_busy),   int'(!m_run));
    check("seq_done",   int'(seq_done),   test_mode ? 1 : int'(m_run));
  endtask

  always @(negedge clk) if (check_en) compare_step();

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_run(input string name, input int budget);
    for (int i = 0; i < budget && !m_run; i++) tick();
    check({name, " reached_done"}, int'(seq_done), 1);
  endtask

  task automatic pin_default_timing(input string name);
    check({name, " rise0"}, m_rise[0], 11);
    check({name, " rise1"}, m_rise[1], 14);
    check({name, " rise2"}, m_rise[2], 17);
    check({name, " rise3"}, m_rise[3], 20);
    check({name, " done_edge"}, m_done_edge, 20);
  endtask

  initial begin
    for (int i = 0; i < ND; i++) begin
      d[i] = DD;
      m_rise[i] = -1;
    end

    // Reset state.
    tick();
    check_en = 1'b1;
    tick();
    tick();
    check("reset dom_rst_no", int'(dom_rst_no), 0);
    check("reset busy", int'(seq_busy), 1);
    check("reset done", int'(seq_done), 0);

    // Scenario 1: default sequence.
    rst_i = 1'b0;
    run_until_run("s1", 60);
    pin_default_timing("s1");

    // Scenario 3: request domain 2 from RUN.
    req = 4'b0100;
    tick();
    req = '0;
    check("s3 dom after req", int'(dom_rst_no), 4'b0011);
    check("s3 busy after req", int'(seq_busy), 1);
    run_until_run("s3", 60);
    check("s3 rise2", m_rise[2], m_req_edge + 11);
    check("s3 rise3", m_rise[3], m_rise[2] + 3);

    // Scenario 4: requests during WAIT are ignored.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 60 && !m_run; i++) begin
      req = (m_wait && m_idx < ND - 1) ? ND'($urandom_range(1, 15)) : '0;
      tick();
    end
    req = '0;
    check("s4 reached_done", int'(seq_done), 1);
    pin_default_timing("s4");

    // Scenario 2: delay[1]=0 and delay[3]=5 written during HOLD.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_delay = 8'd0;
    tick();
    cfg_idx = 2'd3; cfg_delay = 8'd5;
    tick();
    cfg_we = 1'b0;
    run_until_run("s2", 60);
    check("s2 rise0", m_rise[0], 11);
    check("s2 gap01", m_rise[1] - m_rise[0], 1);
    check("s2 gap23", m_rise[3] - m_rise[2], 6);

    // Scenario 5: rst_i one cycle after domain 1 releases restores defaults.
    req = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 40 && m_rise[1] < 0; i++) tick();
    check("s5 dom1 released", int'(dom_rst_no[1]), 1);
    rst_i = 1'b1;
    tick();
    check("s5 dom in reset", int'(dom_rst_no), 0);
    check("s5 done in reset", int'(seq_done), 0);
    rst_i = 1'b0;
    run_until_run("s5", 60);
    pin_default_timing("s5");

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      rst_i     = ($urandom_range(0, 399) == 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_idx   = 2'($urandom_range(0, 3));
      cfg_delay = DW'($urandom_range(0, 6));
      req       = ($urandom_range(0, 9) == 0) ? ND'($urandom_range(1, 15)) : '0;
      tick();
    end
    rst_i = 1'b0; cfg_we = 1'b0; req = '0;

`ifdef RST_SEQ_TEST_BYPASS_EN
    // Scenario 6: bypass follows ~rst_i with no sequencing delay.
    rst_i = 1'b1;
    tick();
    test_mode = 1'b1;
    rst_i = 1'b0;
    #1;
    check("s6 bypass rst low", int'(dom_rst_no), 15);
    check("s6 bypass done", int'(seq_done), 1);
    rst_i = 1'b1;
    #1;
    check("s6 bypass rst high", int'(dom_rst_no), 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("s6 bypass after edge", int'(dom_rst_no), 15);
    test_mode = 1'b0;
    tick();
`endif

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
